// File: rtl/lcd_timing_gen.sv
// Raster timing generator for a parallel RGB565 LCD panel: free-running h/v counters,
// registered sync/enable decodes and a small built-in test pattern source.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 32
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic        lcd_de,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_S = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_E = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] BAR_W    = 11'(H_ACTIVE / 8);

    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_S = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h;
    logic [9:0]  v;
    logic [1:0]  pat_q;

    logic        first_c;
    logic        de_c;
    logic        hsync_c;
    logic        vsync_c;
    logic [10:0] x_c;
    logic [9:0]  y_c;
    logic [1:0]  pat_c;
    logic [2:0]  bar;
    logic [4:0]  r_c;
    logic [5:0]  g_c;
    logic [4:0]  b_c;

    // Decode of the current (h,v); the registers below present it one clock later.
    always_comb begin
        first_c = (h == 11'd0) && (v == 10'd0);
        de_c    = (h < H_ACT) && (v < V_ACT);
        hsync_c = !((h >= H_SYNC_S) && (h < H_SYNC_E));
        vsync_c = !((v >= V_SYNC_S) && (v < V_SYNC_E));
        x_c     = de_c ? h : 11'd0;
        y_c     = de_c ? v : 10'd0;
        // The frame's first sample already uses the newly selected pattern.
        pat_c   = first_c ? pattern_sel : pat_q;

        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_c >= 11'(k) * BAR_W) begin
                bar = bar + 3'd1;
            end
        end

        r_c = 5'd0;
        g_c = 6'd0;
        b_c = 5'd0;
        case (pat_c)
            2'd0: begin
                r_c = {5{~bar[1]}};
                g_c = {6{~bar[2]}};
                b_c = {5{~bar[0]}};
            end
            2'd1: begin
                if ((x_c[4:0] == 5'd0) || (y_c[4:0] == 5'd0)) begin
                    r_c = 5'h1F;
                    g_c = 6'h3F;
                    b_c = 5'h1F;
                end
            end
            2'd2: begin
                r_c = x_c[9:5];
                g_c = y_c[8:3];
                b_c = ~x_c[9:5];
            end
            default: begin
                r_c = 5'd0;
                g_c = 6'd0;
                b_c = 5'd0;
            end
        endcase

        if (!de_c) begin
            r_c = 5'd0;
            g_c = 6'd0;
            b_c = 5'd0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst || !en) begin
            h           <= 11'd0;
            v           <= 10'd0;
            lcd_de      <= 1'b0;
            lcd_hsync   <= 1'b1;
            lcd_vsync   <= 1'b1;
            pix_x       <= 11'd0;
            pix_y       <= 10'd0;
            frame_start <= 1'b0;
            lcd_r       <= 5'd0;
            lcd_g       <= 6'd0;
            lcd_b       <= 5'd0;
            if (rst) begin
                pat_q <= 2'd0;
            end
        end else begin
            if (h == H_LAST) begin
                h <= 11'd0;
                v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 11'd1;
            end
            if (first_c) begin
                pat_q <= pattern_sel;
            end
            lcd_de      <= de_c;
            lcd_hsync   <= hsync_c;
            lcd_vsync   <= vsync_c;
            pix_x       <= x_c;
            pix_y       <= y_c;
            frame_start <= first_c;
            lcd_r       <= r_c;
            lcd_g       <= g_c;
            lcd_b       <= b_c;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Cycle-level scoreboard bench for lcd_timing_gen using a reduced panel geometry
// so that several whole frames fit in a short run.
module tb_lcd_timing_gen;

    localparam int HA = 64;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 4;
    localparam int VA = 40;
    localparam int VF = 2;
    localparam int VS = 3;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int W  = 41;

    logic        pixel_clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pattern_sel;
    logic        lcd_de;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;

    always #5 pixel_clk = ~pixel_clk;

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .en          (en),
        .pattern_sel (pattern_sel),
        .lcd_de      (lcd_de),
        .lcd_hsync   (lcd_hsync),
        .lcd_vsync   (lcd_vsync),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .lcd_r       (lcd_r),
        .lcd_g       (lcd_g),
        .lcd_b       (lcd_b)
    );

    logic [W-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // reference raster position of the next sample and the pattern in force
    int mh   = 0;
    int mv   = 0;
    int mpat = 0;

    // measurements taken from the DUT outputs
    int   cyc        = 0;
    int   last_fs    = -1;
    int   fs_period  = 0;
    int   de_cnt     = 0;
    int   de_frame   = 0;
    int   de_run     = 0;
    int   de_len     = 0;
    int   vs_low     = 0;
    int   vs_frame   = 0;
    int   vs_off     = -1;
    int   hs_fall    = -1;
    int   hs_width   = 0;
    int   hs_period  = 0;
    int   hs_off     = -1;
    logic prev_hs    = 1'b1;
    logic prev_vs    = 1'b1;

    function automatic logic [15:0] model_rgb(input int pat, input int x, input int y);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        int bar;
        r = 5'd0;
        g = 6'd0;
        b = 5'd0;
        case (pat)
            0: begin
                bar = x / (HA / 8);
                case (bar)
                    0: begin r = 5'd31; g = 6'd63; b = 5'd31; end
                    1: begin r = 5'd31; g = 6'd63; b = 5'd0;  end
                    2: begin r = 5'd0;  g = 6'd63; b = 5'd31; end
                    3: begin r = 5'd0;  g = 6'd63; b = 5'd0;  end
                    4: begin r = 5'd31; g = 6'd0;  b = 5'd31; end
                    5: begin r = 5'd31; g = 6'd0;  b = 5'd0;  end
                    6: begin r = 5'd0;  g = 6'd0;  b = 5'd31; end
                    default: begin r = 5'd0; g = 6'd0; b = 5'd0; end
                endcase
            end
            1: begin
                if ((x % 32 == 0) || (y % 32 == 0)) begin
                    r = 5'd31; g = 6'd63; b = 5'd31;
                end
            end
            2: begin
                r = 5'((x / 32) % 32);
                g = 6'((y / 8) % 64);
                b = 5'(31 - (x / 32) % 32);
            end
            default: ;
        endcase
        return {r, g, b};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $display("FAIL %s: observed=%h expected=%h", tag, got, exp);
            $error("%s miscompare", tag);
        end
    endtask

    task automatic update_stats();
        cyc++;
        if (frame_start) begin
            if (last_fs >= 0) begin
                fs_period = cyc - last_fs;
                de_frame  = de_cnt;
                vs_frame  = vs_low;
            end
            last_fs = cyc;
            de_cnt  = 0;
            vs_low  = 0;
            hs_off  = -1;
        end
        if (lcd_de) de_cnt++;
        if (!lcd_vsync) vs_low++;
        if (lcd_de) begin
            de_run++;
        end else begin
            if (de_run > 0) de_len = de_run;
            de_run = 0;
        end
        if (prev_hs && !lcd_hsync) begin
            if (hs_fall >= 0) hs_period = cyc - hs_fall;
            hs_fall = cyc;
            if (hs_off < 0) hs_off = cyc - last_fs;
        end
        if (!prev_hs && lcd_hsync) hs_width = cyc - hs_fall;
        if (prev_vs && !lcd_vsync) vs_off = cyc - last_fs;
        prev_hs = lcd_hsync;
        prev_vs = lcd_vsync;
    endtask

    // One pixel clock: drive inputs, queue the predicted sample, then compare it.
    task automatic step(input logic r_i, input logic en_i, input logic [1:0] sel_i);
        logic [W-1:0] e;
        logic [W-1:0] got;
        logic de, hs, vs, fs;
        int x, y;
        logic [15:0] rgb;
        @(negedge pixel_clk);
        rst         = r_i;
        en          = en_i;
        pattern_sel = sel_i;
        e = {1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 16'd0};
        if (r_i) begin
            mh = 0; mv = 0; mpat = 0;
        end else if (!en_i) begin
            mh = 0; mv = 0;
        end else begin
            fs = (mh == 0) && (mv == 0);
            if (fs) mpat = int'(sel_i);
            de  = (mh < HA) && (mv < VA);
            hs  = !((mh >= HA + HF) && (mh < HA + HF + HS));
            vs  = !((mv >= VA + VF) && (mv < VA + VF + VS));
            x   = de ? mh : 0;
            y   = de ? mv : 0;
            rgb = de ? model_rgb(mpat, x, y) : 16'd0;
            e   = {de, hs, vs, fs, 11'(x), 10'(y), rgb};
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
        end
        exp_q.push_back(e);
        @(posedge pixel_clk);
        #1;
        got = {lcd_de, lcd_hsync, lcd_vsync, frame_start, pix_x, pix_y, lcd_r, lcd_g, lcd_b};
        check($sformatf("sample@%0d", cyc), got, exp_q.pop_front());
        update_stats();
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b1;
        pattern_sel = 2'd0;

        // reset with en high: idle outputs
        repeat (3) step(1'b1, 1'b1, 2'd0);

        // two full frames of bars plus margin
        repeat (2 * HT * VT + 2 * HT) step(1'b0, 1'b1, 2'd0);
        check("fs_period", W'(fs_period), W'(HT * VT));
        check("hs_offset", W'(hs_off),    W'(HA + HF));
        check("hs_width",  W'(hs_width),  W'(HS));
        check("line_period", W'(hs_period), W'(HT));
        check("de_run",    W'(de_len),    W'(HA));
        check("de_frame",  W'(de_frame),  W'(HA * VA));
        check("vs_low",    W'(vs_frame),  W'(VS * HT));
        check("vs_offset", W'(vs_off),    W'((VA + VF) * HT));

        // pattern_sel changes mid-frame; takes effect only at the next frame
        for (int i = 0; i < 2 * HT * VT && !(mh == 0 && mv == 20); i++) step(1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 2 * HT * VT && !(mh == 0 && mv == 0); i++) step(1'b0, 1'b1, 2'd1);
        repeat (HT * VT / 2) step(1'b0, 1'b1, 2'd1);
        repeat (HT * VT / 2) step(1'b0, 1'b1, 2'd2);
        repeat (HT * VT / 2) step(1'b0, 1'b1, 2'd2);
        repeat (HT * VT / 2) step(1'b0, 1'b1, 2'd3);
        repeat (HT * VT / 2) step(1'b0, 1'b1, 2'd0);

        // en dropped mid-line, then restored
        for (int i = 0; i < 2 * HT * VT && !(mh == 50 && mv == 10); i++) step(1'b0, 1'b1, 2'd0);
        repeat (5) step(1'b0, 1'b0, 2'd0);
        repeat (2 * HT) step(1'b0, 1'b1, 2'd0);

        // one-clock reset during hsync
        for (int i = 0; i < 2 * HT && mh != HA + HF + 3; i++) step(1'b0, 1'b1, 2'd1);
        step(1'b1, 1'b1, 2'd1);
        repeat (2 * HT) step(1'b0, 1'b1, 2'd2);

        // random en/rst/pattern traffic
        repeat (3000) step($urandom_range(0, 199) == 0, $urandom_range(0, 49) != 0,
                           2'($urandom_range(0, 3)));
        repeat (HT * VT + HT) step(1'b0, 1'b1, 2'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 40, horizontal front porch in pixel clocks.
REQ-003 Parameter H_SYNC, default 128, hsync pulse width in pixel clocks.
REQ-004 Parameter H_BP, default 88, horizontal back porch; H_TOTAL = sum of the four, 1056 by default.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 13, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 3, vsync pulse width in lines.
REQ-008 Parameter V_BP, default 32, vertical back porch; V_TOTAL = sum of the four, 528 by default.
REQ-009 pixel_clk  in  1  single clock (PLL divided output, 33.33 MHz nominal); all logic on rising edge.
REQ-010 rst  in  1  reset, synchronous, active-high.
REQ-011 en  in  1  level; 1 = generate timing, 0 = hold idle.
REQ-012 pattern_sel  in  2  test pattern select.
REQ-013 lcd_de  out  1  data enable, high during active pixels.
REQ-014 lcd_hsync  out  1  horizontal sync, active low.
REQ-015 lcd_vsync  out  1  vertical sync, active low.
REQ-016 pix_x  out  11  current active column, 0..H_ACTIVE-1, 0 outside active.
REQ-017 pix_y  out  10  current active line, 0..V_ACTIVE-1, 0 outside active.
REQ-018 frame_start  out  1  one-cycle pulse at the first pixel of each frame.
REQ-019 lcd_r / lcd_g / lcd_b  out  5 / 6 / 5  RGB565 pixel data.

Function
REQ-020 The block SHALL keep internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1); h wraps to 0 after H_TOTAL-1, and v increments on that wrap, wrapping to 0 after V_TOTAL-1.
REQ-021 The line order SHALL be active [0,H_ACTIVE), front porch, sync, back porch; the frame order SHALL be the same in lines.
REQ-022 All outputs SHALL be registered decodes of (h,v), one pixel_clk of latency; the first output sample after the idle-to-run transition SHALL describe h=0, v=0.
REQ-023 lcd_de SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-024 lcd_hsync SHALL be 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking.
REQ-025 lcd_vsync SHALL be 0 for every h of lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
REQ-026 frame_start SHALL be 1 only in the sample describing h=0, v=0.
REQ-027 pattern_sel SHALL be latched only when the h=0, v=0 sample is produced; a change mid-frame takes effect at the next frame.
REQ-028 Pattern 0 SHALL produce 8 equal vertical bars of width H_ACTIVE/8, left to right: white, yellow, cyan, green, magenta, red, blue, black (components full-scale or 0).
REQ-029 Pattern 1 SHALL produce a grid: white where pix_x[4:0]==0 or pix_y[4:0]==0, black elsewhere.
REQ-030 Pattern 2 SHALL produce a gradient: lcd_r=pix_x[9:5], lcd_g=pix_y[8:3], lcd_b=~pix_x[9:5].
REQ-031 Pattern 3 SHALL produce solid black.
REQ-032 lcd_r, lcd_g, and lcd_b SHALL be 0 whenever lcd_de=0.
REQ-033 When en=0, counters SHALL be forced to 0 at the next edge and outputs SHALL show idle values (REQ-035) from the following edge.
REQ-034 When en returns to 1, generation SHALL restart from h=0, v=0, with frame_start asserted in the first sample.

Reset
REQ-035 While rst=1: counters=0; lcd_de=0; lcd_hsync=1; lcd_vsync=1; pix_x=0; pix_y=0; frame_start=0; RGB=0; latched pattern=0.
REQ-036 rst SHALL take priority over en.
REQ-037 Asserting rst mid-frame SHALL produce idle outputs at the next edge; release with en=1 SHALL behave as REQ-034.

Verification
REQ-038 Release rst with en=1 and defaults -> frame_start on the first sample; lcd_de high for 800 consecutive clocks; hsync low for 128 clocks starting 840 clocks after the line start; line period 1056.
REQ-039 Run 2 full frames -> frame_start period is exactly 557568 clocks; vsync low for 3 lines (3168 clocks) starting at line 493; 480 DE lines per frame.
REQ-040 Pattern 0, line 0 -> pix_x=0..99 gives RGB=(31,63,31); pix_x=100 gives (31,63,0); pix_x=700..799 gives (0,0,0); RGB=0 at h=800.
REQ-041 Change pattern_sel 0->1 at line 200 -> bars continue to frame end; next frame pix_x=32, pix_y=5 gives white and pix_x=33, pix_y=5 gives black.
REQ-042 Deassert en at h=500, v=100 -> idle outputs (hsync=vsync=1, de=0) within 2 clocks; reassert en -> frame_start on the first sample and pix_x counts from 0.
REQ-043 Assert rst for 1 clock mid-sync (h=900) with en=1 -> all outputs at reset values for one sample, then restart at h=0, v=0 with frame_start.
